// File: rtl/nor4_x4.sv
// nor4_x4 -- four-input NOR cell wrapper (X4 drive class) with a registered
// activity monitor.
//
// Parameters:
//   CNT_W    width of the zn_cnt high-cycle counter (2..32)
//
// Ports:
//   clk      system clock, all state updates on its rising edge
//   rst_n    asynchronous active-low reset of the monitor registers
//   A1..A4   NOR inputs
//   ZN       combinational ~(A1|A2|A3|A4), independent of clk and rst_n
//   cnt_clr  synchronous clear of zn_cnt (wins over increment)
//   zn_q     ZN registered on clk
//   zn_rise  one-cycle pulse when zn_q goes 0 -> 1
//   zn_fall  one-cycle pulse when zn_q goes 1 -> 0
//   zn_cnt   saturating count of cycles with zn_q == 1
module nor4_x4 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             A4,
    output logic             ZN,
    input  logic             cnt_clr,
    output logic             zn_q,
    output logic             zn_rise,
    output logic             zn_fall,
    output logic [CNT_W-1:0] zn_cnt
);

    // Plain continuous NOR keeps 4-state behaviour: a 1 on any input
    // dominates X/Z on the others.
    assign ZN = ~(A1 | A2 | A3 | A4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zn_q    <= 1'b0;
            zn_rise <= 1'b0;
            zn_fall <= 1'b0;
        end else begin
            zn_q    <= ZN;
            zn_rise <= ZN & ~zn_q;
            zn_fall <= ~ZN & zn_q;
        end
    end

    // Counts on the registered copy, so a cycle is counted one edge after
    // zn_q shows it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zn_cnt <= '0;
        end else if (cnt_clr) begin
            zn_cnt <= '0;
        end else if (zn_q && (zn_cnt != '1)) begin
            zn_cnt <= zn_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_nor4_x4.sv
module tb_nor4_x4;

    typedef struct {
        logic [3:0] a;      // {A1, A2, A3, A4}
        logic       zn;
    } vec_t;

    typedef struct {
        logic        q;
        logic        rise;
        logic        fall;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        a1, a2, a3, a4;
    logic        cnt_clr;
    logic        zn, zn4;
    logic        zn_q, zn_rise, zn_fall;
    logic [15:0] zn_cnt;
    logic        zn_q4, zn_rise4, zn_fall4;
    logic [3:0]  zn_cnt4;

    int checks = 0;
    int errors = 0;

    vec_t tv [16];
    logic zq [$];
    exp_t sq [$];

    // reference model state
    logic        m_q, m_rise, m_fall;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;

    nor4_x4 #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4),
        .ZN(zn), .cnt_clr(cnt_clr),
        .zn_q(zn_q), .zn_rise(zn_rise), .zn_fall(zn_fall), .zn_cnt(zn_cnt)
    );

    nor4_x4 #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4),
        .ZN(zn4), .cnt_clr(cnt_clr),
        .zn_q(zn_q4), .zn_rise(zn_rise4), .zn_fall(zn_fall4), .zn_cnt(zn_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_a(input logic [3:0] v);
        {a1, a2, a3, a4} = v;
    endtask

    task automatic model_reset();
        m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0; m_cnt4 = '0;
    endtask

    // Predict the next edge from the currently driven inputs, push it, then
    // let the edge happen and compare both instances against the prediction.
    task automatic cycle(input string name);
        logic z;
        exp_t e;
        z = ~(a1 | a2 | a3 | a4);
        e.rise = z & ~m_q;
        e.fall = ~z & m_q;
        if (cnt_clr) begin
            e.cnt = '0; e.cnt4 = '0;
        end else begin
            e.cnt  = (m_q && m_cnt  != 16'hFFFF) ? m_cnt  + 16'd1 : m_cnt;
            e.cnt4 = (m_q && m_cnt4 != 4'hF)     ? m_cnt4 + 4'd1  : m_cnt4;
        end
        e.q = z;
        m_q = e.q; m_rise = e.rise; m_fall = e.fall; m_cnt = e.cnt; m_cnt4 = e.cnt4;
        sq.push_back(e);
        @(posedge clk);
        #1;
        e = sq.pop_front();
        check({name, ".zn_q"},    {31'd0, zn_q},    {31'd0, e.q});
        check({name, ".zn_rise"}, {31'd0, zn_rise}, {31'd0, e.rise});
        check({name, ".zn_fall"}, {31'd0, zn_fall}, {31'd0, e.fall});
        check({name, ".zn_cnt"},  {16'd0, zn_cnt},  {16'd0, e.cnt});
        check({name, ".zn_cnt4"}, {28'd0, zn_cnt4}, {28'd0, e.cnt4});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tv[i].a  = 4'(i);
            tv[i].zn = (i == 0);
        end

        rst_n = 1'b0;
        cnt_clr = 1'b0;
        set_a(4'b0000);
        model_reset();
        #3;

        // truth table in reset
        for (int i = 0; i < 16; i++) begin
            set_a(tv[i].a);
            zq.push_back(tv[i].zn);
            #10;
            check("tt_rst.ZN", {31'd0, zn}, {31'd0, zq.pop_front()});
        end
        check("rst.zn_q",    {31'd0, zn_q},    32'd0);
        check("rst.zn_rise", {31'd0, zn_rise}, 32'd0);
        check("rst.zn_fall", {31'd0, zn_fall}, 32'd0);
        check("rst.zn_cnt",  {16'd0, zn_cnt},  32'd0);

        // truth table running
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_a(tv[i].a);
            zq.push_back(tv[i].zn);
            #10;
            check("tt_run.ZN", {31'd0, zn}, {31'd0, zq.pop_front()});
            check("tt_run.ZN4", {31'd0, zn4}, {31'd0, tv[i].zn});
        end

        // clean restart for the clocked sequences
        @(negedge clk);
        rst_n = 1'b0;
        set_a(4'b0000);
        #1;
        check("rst2.zn_q",   {31'd0, zn_q},   32'd0);
        check("rst2.zn_cnt", {16'd0, zn_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // counter: 10 cycles of 0000 -> 9
        for (int k = 0; k < 10; k++) begin
            cycle("hold0");
            if (k == 0) check("first_rise", {31'd0, zn_rise}, 32'd1);
        end
        check("cnt_after10", {16'd0, zn_cnt}, 32'd9);

        // clear wins over increment
        cnt_clr = 1'b1;
        cycle("clr");
        check("clr_cnt", {16'd0, zn_cnt}, 32'd0);
        cnt_clr = 1'b0;

        // saturation of the 4-bit instance
        for (int k = 0; k < 20; k++) cycle("sat");
        check("sat_cnt4", {28'd0, zn_cnt4}, 32'd15);
        check("sat_cnt16", {16'd0, zn_cnt}, 32'd20);

        // latency and fall pulse: 0000 -> 0001
        set_a(4'b0001);
        cycle("lat1");
        check("lat_zn_q0",  {31'd0, zn_q},    32'd0);
        check("lat_fall1",  {31'd0, zn_fall}, 32'd1);
        check("lat_rise0",  {31'd0, zn_rise}, 32'd0);
        cnt_clr = 1'b1;
        cycle("lat2");
        check("lat_fall_once", {31'd0, zn_fall}, 32'd0);
        cnt_clr = 1'b0;

        // build zn_q = 1, zn_cnt = 5 then async reset between edges
        set_a(4'b0000);
        for (int k = 0; k < 6; k++) cycle("pre_rst");
        check("pre_rst_cnt", {16'd0, zn_cnt}, 32'd5);
        check("pre_rst_q",   {31'd0, zn_q},   32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.zn_q",    {31'd0, zn_q},    32'd0);
        check("arst.zn_rise", {31'd0, zn_rise}, 32'd0);
        check("arst.zn_fall", {31'd0, zn_fall}, 32'd0);
        check("arst.zn_cnt",  {16'd0, zn_cnt},  32'd0);
        check("arst.ZN",      {31'd0, zn},      32'd1);
        @(posedge clk);
        #1;
        check("arst_hold.zn_q", {31'd0, zn_q}, 32'd0);

        // restart with 0000 held: rise after the first edge, counting after
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle("restart1");
        check("restart_rise", {31'd0, zn_rise}, 32'd1);
        cycle("restart2");
        check("restart_cnt", {16'd0, zn_cnt}, 32'd1);

        // a 1 on any input dominates an unknown
        a1 = 1'b1; a2 = 1'bx; a3 = 1'b0; a4 = 1'b0;
        #1;
        check("x_dominated", {31'd0, zn}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
